prog_loader: RTL and testbench

- Hardware program loader: the write-side counterpart of the bench's backdoor image load.
- Receives a framed byte stream (length, base address, 64-bit little-endian words, checksum) over a valid/ready byte interface.
- Writes each word through one memory write port; Top fans this port out to both im and dm.
- Holds the CPU in reset until the image is loaded and the checksum verifies.

---
 rtl/prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_prog_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Hardware program loader. Receives a framed byte stream
//     len (4 bytes LE) | base (4 bytes LE) | len x 64-bit LE words | xor checksum
//   and writes each word through a single memory write port. The CPU is held
//   in reset (cpu_hold=1) until a complete image with a good checksum is in.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start         one-cycle pulse, starts a load from IDLE, DONE or ERR
//   in_data       stream byte
//   in_valid      in_data valid
//   in_ready      loader accepts a byte this cycle
//   mem_we        write request
//   mem_addr      byte address of the word being written
//   mem_wdata     word being written
//   mem_ready     memory accepts the write this cycle
//   cpu_hold      CPU reset, high = held
//   done          load finished with good checksum (sticky until next start)
//   error         load aborted (sticky until next start)
//   words_written words accepted by memory in the current load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int MAX_WORDS = 16384,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [31:0]       words_written
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_BASE, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t              state_reg, state_next;
    logic [31:0]         len_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [31:0]         index_reg;
    logic [2:0]          bcnt_reg;
    logic [63:0]         buf_reg;
    logic [7:0]          csum_reg;
    logic [31:0]         words_written_reg;

    logic                take;
    logic [31:0]         len_asm;
    logic [31:0]         base_asm;

    assign take = in_valid && in_ready;

    // Header fields with the byte currently on the bus merged in, so the
    // 4th-byte decisions see the complete value in the same cycle.
    always_comb begin
        len_asm  = len_reg;
        base_asm = base_reg[31:0];
        len_asm[8*bcnt_reg[1:0] +: 8]  = in_data;
        base_asm[8*bcnt_reg[1:0] +: 8] = in_data;
    end

    // -------------------------------------------------------------------------
    // Next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_LEN;
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (take && bcnt_reg == 3'd3)
                    state_next = (len_asm > 32'(MAX_WORDS)) ? S_ERR : S_BASE;
            end
            S_BASE: begin
                in_ready = 1'b1;
                if (take && bcnt_reg == 3'd3) begin
                    if (base_asm[2:0] != 3'd0) state_next = S_ERR;
                    else if (len_reg == 32'd0)  state_next = S_CSUM;
                    else                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (take && bcnt_reg == 3'd7) state_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (mem_ready)
                    state_next = (index_reg + 32'd1 == len_reg) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (take) state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= S_IDLE;
            len_reg           <= '0;
            base_reg          <= '0;
            index_reg         <= '0;
            bcnt_reg          <= '0;
            buf_reg           <= '0;
            csum_reg          <= '0;
            words_written_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        len_reg           <= '0;
                        base_reg          <= '0;
                        index_reg         <= '0;
                        bcnt_reg          <= '0;
                        buf_reg           <= '0;
                        csum_reg          <= '0;
                        words_written_reg <= '0;
                    end
                end
                S_LEN: begin
                    if (take) begin
                        len_reg  <= len_asm;
                        bcnt_reg <= (bcnt_reg == 3'd3) ? 3'd0 : bcnt_reg + 3'd1;
                    end
                end
                S_BASE: begin
                    if (take) begin
                        base_reg <= ADDR_W'(base_asm);
                        bcnt_reg <= (bcnt_reg == 3'd3) ? 3'd0 : bcnt_reg + 3'd1;
                    end
                end
                S_DATA: begin
                    if (take) begin
                        buf_reg[8*bcnt_reg +: 8] <= in_data;
                        csum_reg                 <= csum_reg ^ in_data;
                        bcnt_reg                 <= bcnt_reg + 3'd1;  // wraps to 0 after byte 7
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        index_reg         <= index_reg + 32'd1;
                        words_written_reg <= words_written_reg + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address wraps modulo 2^ADDR_W; index and buffer only change outside
    // WRITE, so address and data hold steady under backpressure.
    assign mem_addr      = base_reg + (ADDR_W'(index_reg) << 3);
    assign mem_wdata     = buf_reg;
    assign words_written = words_written_reg;

    // Status flags come straight from the state register.
    assign done     = (state_reg == S_DONE);
    assign error    = (state_reg == S_ERR);
    assign cpu_hold = (state_reg != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int MAX_WORDS = 16384;
    localparam int ADDR_W    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_ready = 1'b1;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [31:0]       words_written;

    int checks   = 0;
    int failures = 0;

    // write log filled by the monitor
    int          wr_total = 0;
    logic [63:0] wr_addr [64];
    logic [63:0] wr_data [64];

    prog_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .cpu_hold(cpu_hold), .done(done),
        .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    // A write is accepted at the next rising edge when both are high.
    always @(negedge clk) begin
        if (rst && mem_we && mem_ready) begin
            wr_addr[wr_total % 64] = mem_addr;
            wr_data[wr_total % 64] = mem_wdata;
            wr_total = wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Scenario-1 frame: len=2, base=0, bytes 0x01..0x10, checksum given.
    task automatic nominal_frame(input logic [7:0] csum);
        pulse_start();
        send_word32(32'd2);
        send_word32(32'd0);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        send_byte(csum);
    endtask

    task automatic check_nominal(input string tag, input int w0);
        chk({tag, "_nwr"},   64'(wr_total - w0), 64'd2);
        chk({tag, "_a0"},    wr_addr[w0 % 64], 64'h0);
        chk({tag, "_d0"},    wr_data[w0 % 64], 64'h0807060504030201);
        chk({tag, "_a1"},    wr_addr[(w0 + 1) % 64], 64'h8);
        chk({tag, "_d1"},    wr_data[(w0 + 1) % 64], 64'h100F0E0D0C0B0A09);
        chk({tag, "_ww"},    64'(words_written), 64'd2);
        chk({tag, "_done"},  64'(done), 64'd1);
        chk({tag, "_hold"},  64'(cpu_hold), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        int w0;

        // ---- reset state ----
        #12;
        chk("rst_hold",  64'(cpu_hold), 64'd1);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_we",    64'(mem_we), 64'd0);
        chk("rst_addr",  mem_addr, 64'd0);
        chk("rst_ww",    64'(words_written), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- 1: nominal load ----
        w0 = wr_total;
        nominal_frame(8'h10);
        check_nominal("nom", w0);
        $display("txn nominal: writes=%0d done=%0b", wr_total - w0, done);

        // ---- 2: bad checksum ----
        w0 = wr_total;
        pulse_start();
        chk("restart_hold", 64'(cpu_hold), 64'd1);
        chk("restart_done", 64'(done), 64'd0);
        send_word32(32'd2);
        send_word32(32'd0);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        send_byte(8'h11);
        chk("bad_nwr",   64'(wr_total - w0), 64'd2);
        chk("bad_error", 64'(error), 64'd1);
        chk("bad_done",  64'(done), 64'd0);
        chk("bad_hold",  64'(cpu_hold), 64'd1);
        chk("bad_ready", 64'(in_ready), 64'd0);
        $display("txn bad_csum: writes=%0d error=%0b", wr_total - w0, error);

        // ---- 3: misaligned base ----
        w0 = wr_total;
        pulse_start();
        send_word32(32'd1);
        send_word32(32'd4);
        chk("mis_error", 64'(error), 64'd1);
        chk("mis_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mis_nwr",   64'(wr_total - w0), 64'd0);
        $display("txn misaligned: error=%0b", error);

        // ---- 4: oversize length ----
        pulse_start();
        send_word32(32'(MAX_WORDS + 1));
        chk("big_error", 64'(error), 64'd1);
        chk("big_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("big_ready2", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        $display("txn oversize: error=%0b", error);

        // ---- 5: write backpressure ----
        w0 = wr_total;
        mem_ready = 1'b0;
        pulse_start();
        send_word32(32'd2);
        send_word32(32'd0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        for (int c = 0; c < 3; c++) begin
            chk("bp_we",    64'(mem_we), 64'd1);
            chk("bp_addr",  mem_addr, 64'h0);
            chk("bp_wdata", mem_wdata, 64'h0807060504030201);
            chk("bp_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        for (int i = 9; i <= 16; i++) send_byte(8'(i));
        send_byte(8'h10);
        check_nominal("bp", w0);
        $display("txn backpressure: writes=%0d done=%0b", wr_total - w0, done);

        // ---- 6: reset mid-load, restart ----
        pulse_start();
        send_word32(32'd2);
        send_word32(32'd0);
        for (int i = 1; i <= 11; i++) send_byte(8'(i));
        rst = 1'b0;
        #1;
        chk("mid_hold",  64'(cpu_hold), 64'd1);
        chk("mid_ready", 64'(in_ready), 64'd0);
        chk("mid_we",    64'(mem_we), 64'd0);
        chk("mid_addr",  mem_addr, 64'd0);
        chk("mid_wdata", mem_wdata, 64'd0);
        chk("mid_ww",    64'(words_written), 64'd0);
        chk("mid_done",  64'(done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        w0 = wr_total;
        nominal_frame(8'h10);
        check_nominal("rerun", w0);
        $display("txn reset_rerun: writes=%0d done=%0b", wr_total - w0, done);

        w0 = wr_total;
        pulse_start();
        chk("z_hold_after_start", 64'(cpu_hold), 64'd1);
        send_word32(32'd0);
        send_word32(32'd8);
        send_byte(8'h00);
        chk("z_nwr",  64'(wr_total - w0), 64'd0);
        chk("z_done", 64'(done), 64'd1);
        chk("z_hold", 64'(cpu_hold), 64'd0);
        chk("z_ww",   64'(words_written), 64'd0);
        $display("txn zero_len: writes=%0d done=%0b", wr_total - w0, done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
